// File: rtl/makina_pkg.sv
// ----------------------------------------------------------------------------
// makina_pkg
// Shared definitions for the jump datapath: the jump micro-op encoding (also
// used by the instruction decoder) and its field width.
// No ports; imported with "import makina_pkg::*;".
// ----------------------------------------------------------------------------
package makina_pkg;

    localparam int JUMP_OP_W = 3;

    // Jump micro-op encoding.
    // JJMP is unconditional; JNOP still flows through the pipe but never redirects.
    typedef enum logic [JUMP_OP_W-1:0] {
        JEQ  = 3'b000,
        JNE  = 3'b001,
        JGT  = 3'b010,
        JLT  = 3'b011,
        JGE  = 3'b100,
        JLE  = 3'b101,
        JJMP = 3'b110,
        JNOP = 3'b111
    } jump_op_e;

endpackage

// File: rtl/branch_cond_eval.sv
// ----------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational jump-condition evaluator.
// Ports:
//   i_op      jump micro-op (jump_op_e encoding)
//   i_signed  1 = two's-complement compare, 0 = unsigned compare
//   i_a, i_b  operands
//   o_taken   1 when the jump condition holds
// ----------------------------------------------------------------------------
module branch_cond_eval
    import makina_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [JUMP_OP_W-1:0] i_op,
    input  logic                 i_signed,
    input  logic [DATA_W-1:0]    i_a,
    input  logic [DATA_W-1:0]    i_b,
    output logic                 o_taken
);

    logic w_eq;
    logic w_lt;

    // Every relational op is derived from a single equality and a single
    // less-than, so the signed/unsigned choice only affects one comparator.
    assign w_eq = (i_a == i_b);
    assign w_lt = i_signed ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);

    always_comb begin
        o_taken = 1'b0;
        case (jump_op_e'(i_op))
            JEQ:  o_taken = w_eq;
            JNE:  o_taken = !w_eq;
            JGT:  o_taken = !w_lt && !w_eq;
            JLT:  o_taken = w_lt;
            JGE:  o_taken = !w_lt;
            JLE:  o_taken = w_lt || w_eq;
            JJMP: o_taken = 1'b1;
            JNOP: o_taken = 1'b0;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
// Pipelined branch resolver. Accepts one jump micro-op per cycle, evaluates
// its condition and returns taken flag, redirect target and link address
// LATENCY (1 or 2) cycles later. A flush kills everything in flight.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               discard all in-flight and incoming micro-ops
//   i_in_valid/o_in_ready input handshake
//   i_in_op, i_in_signed  jump op and compare signedness
//   i_in_a, i_in_b        operands
//   i_in_pc, i_in_target  micro-op PC and jump destination
//   o_out_valid/i_out_ready output handshake
//   o_out_taken           branch taken
//   o_out_target          target if taken, else 0
//   o_out_link            pc + INSTR_INC (wrapping)
//   o_taken_count         saturating count of delivered taken results
// ----------------------------------------------------------------------------
module branch_resolve_unit
    import makina_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int LATENCY   = 2,
    parameter int INSTR_INC = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [JUMP_OP_W-1:0] i_in_op,
    input  logic                 i_in_signed,
    input  logic [DATA_W-1:0]    i_in_a,
    input  logic [DATA_W-1:0]    i_in_b,
    input  logic [ADDR_W-1:0]    i_in_pc,
    input  logic [ADDR_W-1:0]    i_in_target,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_out_taken,
    output logic [ADDR_W-1:0]    o_out_target,
    output logic [ADDR_W-1:0]    o_out_link,
    output logic [CNT_W-1:0]     o_taken_count
);

    // Inputs of the condition evaluator and of the result register; they come
    // either from the operand stage (LATENCY=2) or straight from the ports.
    logic [JUMP_OP_W-1:0] w_evalOp;
    logic                 w_evalSigned;
    logic [DATA_W-1:0]    w_evalA;
    logic [DATA_W-1:0]    w_evalB;
    logic                 w_resInValid;
    logic [ADDR_W-1:0]    w_resInPc;
    logic [ADDR_W-1:0]    w_resInTarget;
    logic                 w_taken;

    logic                 r_resValid;
    logic                 r_resTaken;
    logic [ADDR_W-1:0]    r_resTarget;
    logic [ADDR_W-1:0]    r_resLink;
    logic [CNT_W-1:0]     r_takenCount;

    logic                 w_resEn;
    logic                 w_outFire;

    // The result stage may load whenever it is empty or its content leaves.
    assign w_resEn   = !r_resValid || i_out_ready;
    // A result presented during a flush is squashed, so it never counts.
    assign w_outFire = r_resValid && i_out_ready && !i_flush;

    generate
        if (LATENCY == 2) begin : g_lat2
            logic                 r_s1Valid;
            logic [JUMP_OP_W-1:0] r_s1Op;
            logic                 r_s1Signed;
            logic [DATA_W-1:0]    r_s1A;
            logic [DATA_W-1:0]    r_s1B;
            logic [ADDR_W-1:0]    r_s1Pc;
            logic [ADDR_W-1:0]    r_s1Target;
            logic                 w_s1En;

            assign w_s1En     = !r_s1Valid || w_resEn;
            assign o_in_ready = !i_flush && w_s1En;

            // Operand stage: captures the raw micro-op. Payload only loads
            // on a real transfer so idle cycles do not toggle the datapath.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_s1Valid  <= 1'b0;
                    r_s1Op     <= '0;
                    r_s1Signed <= 1'b0;
                    r_s1A      <= '0;
                    r_s1B      <= '0;
                    r_s1Pc     <= '0;
                    r_s1Target <= '0;
                end else if (i_flush) begin
                    r_s1Valid <= 1'b0;
                end else if (w_s1En) begin
                    r_s1Valid <= i_in_valid;
                    if (i_in_valid) begin
                        r_s1Op     <= i_in_op;
                        r_s1Signed <= i_in_signed;
                        r_s1A      <= i_in_a;
                        r_s1B      <= i_in_b;
                        r_s1Pc     <= i_in_pc;
                        r_s1Target <= i_in_target;
                    end
                end
            end

            assign w_evalOp      = r_s1Op;
            assign w_evalSigned  = r_s1Signed;
            assign w_evalA       = r_s1A;
            assign w_evalB       = r_s1B;
            assign w_resInValid  = r_s1Valid;
            assign w_resInPc     = r_s1Pc;
            assign w_resInTarget = r_s1Target;
        end else begin : g_lat1
            if (LATENCY != 1) begin : g_badLatency
                $error("branch_resolve_unit: LATENCY must be 1 or 2");
            end

            assign o_in_ready    = !i_flush && w_resEn;
            assign w_evalOp      = i_in_op;
            assign w_evalSigned  = i_in_signed;
            assign w_evalA       = i_in_a;
            assign w_evalB       = i_in_b;
            assign w_resInValid  = i_in_valid;
            assign w_resInPc     = i_in_pc;
            assign w_resInTarget = i_in_target;
        end
    endgenerate

    branch_cond_eval #(
        .DATA_W (DATA_W)
    ) u_condEval (
        .i_op     (w_evalOp),
        .i_signed (w_evalSigned),
        .i_a      (w_evalA),
        .i_b      (w_evalB),
        .o_taken  (w_taken)
    );

    // Result stage: holds taken/target/link. It only loads when w_resEn is
    // high, which keeps the outputs frozen while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resValid  <= 1'b0;
            r_resTaken  <= 1'b0;
            r_resTarget <= '0;
            r_resLink   <= '0;
        end else if (i_flush) begin
            r_resValid <= 1'b0;
        end else if (w_resEn) begin
            r_resValid <= w_resInValid;
            if (w_resInValid) begin
                r_resTaken  <= w_taken;
                r_resTarget <= w_taken ? w_resInTarget : '0;
                r_resLink   <= w_resInPc + ADDR_W'(INSTR_INC);
            end
        end
    end

    // Saturating count of taken results actually handed to the consumer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_takenCount <= '0;
        end else if (w_outFire && r_resTaken && (r_takenCount != {CNT_W{1'b1}})) begin
            r_takenCount <= r_takenCount + 1'b1;
        end
    end

    assign o_out_valid   = r_resValid;
    assign o_out_taken   = r_resTaken;
    assign o_out_target  = r_resTarget;
    assign o_out_link    = r_resLink;
    assign o_taken_count = r_takenCount;

endmodule
